// File: rtl/seq_divider_pkg.sv
// Shared definitions for the byte-mapped sequential divider: FSM states,
// CTRL/STAT bit positions and register-offset helpers.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_t;

  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_ACK    = 3;

  localparam int STAT_BUSY   = 7;
  localparam int STAT_DONE   = 6;
  localparam int STAT_DIV0   = 5;
  localparam int STAT_IRQ_EN = 2;
  localparam int STAT_SIGNED = 1;

  function automatic int numer_base(input int nb);
    return 0 * nb;
  endfunction

  function automatic int denom_base(input int nb);
    return nb;
  endfunction

  function automatic int quot_base(input int nb);
    return 2 * nb;
  endfunction

  function automatic int rem_base(input int nb);
    return 3 * nb;
  endfunction

  function automatic int ctrl_off(input int nb);
    return 4 * nb;
  endfunction

endpackage

// File: rtl/seq_divider_core.sv
// Restoring divide engine: one quotient bit per cycle, sign fix-up and
// divide-by-zero handling, with sticky done/div0 cleared by ack or start.
module seq_divider_core
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             divclk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pr;
  logic [WIDTH-1:0] qw;
  logic [WIDTH-1:0] dw;
  logic             neg_q;
  logic             neg_r;
  logic             div0_pend;
  logic [WIDTH:0]   shifted;
  logic             take;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  assign shifted = {pr, qw[WIDTH-1]};
  assign take    = (shifted >= {1'b0, dw});
  assign busy    = (state != IDLE);

  always_ff @(posedge divclk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (denom == '0) ? FIX : RUN;
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge divclk) begin
    if (reset) begin
      cnt       <= '0;
      pr        <= '0;
      qw        <= '0;
      dw        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0_pend <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
      quot      <= '0;
      rem       <= '0;
    end else begin
      if (ack) begin
        done <= 1'b0;
        div0 <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            done  <= 1'b0;
            div0  <= 1'b0;
            neg_q <= signed_mode & (numer[WIDTH-1] ^ denom[WIDTH-1]);
            neg_r <= signed_mode & numer[WIDTH-1];
            dw    <= mag(denom, signed_mode);
            pr    <= '0;
            cnt   <= CNT_W'(WIDTH - 1);
            // On divide-by-zero the raw numerator is parked in qw for REM.
            if (denom == '0) begin
              div0_pend <= 1'b1;
              qw        <= numer;
            end else begin
              div0_pend <= 1'b0;
              qw        <= mag(numer, signed_mode);
            end
          end
        end
        RUN: begin
          pr  <= take ? WIDTH'(shifted - {1'b0, dw}) : shifted[WIDTH-1:0];
          qw  <= {qw[WIDTH-2:0], take};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          div0 <= div0_pend;
          if (div0_pend) begin
            quot <= '1;
            rem  <= qw;
          end else begin
            quot <= neg_q ? -qw : qw;
            rem  <= neg_r ? -pr : pr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seq_divider_regs.sv
// Byte-wide register front end for the sequential divider: operand
// registers, CTRL/STAT, start generation and the combinational read mux.
module seq_divider_regs
  import seq_divider_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  bit AUTO_START = 1'b1,
  localparam int NB         = WIDTH / 8,
  localparam int ADDR_W     = $clog2(4 * NB + 1)
) (
  input  logic              divclk,
  input  logic              reset,
  input  logic              cs,
  input  logic              rwb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic              o_busy,
  output logic              o_irq
);

  logic [WIDTH-1:0] numer, numer_next;
  logic [WIDTH-1:0] denom, denom_next;
  logic             signed_mode;
  logic             irq_en;
  logic [31:0]      addr_idx;
  logic             wr;
  logic             ctrl_wr;
  logic             signed_eff;
  logic             start;
  logic             ack;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [7:0]       stat;

  assign addr_idx = 32'(addr);
  assign wr       = cs & ~rwb;
  assign ctrl_wr  = wr && (addr_idx == 32'(ctrl_off(NB)));

  // The core latches operands and mode on the start edge, so it is fed the
  // post-write values; a byte or mode written by the starting access counts.
  always_comb begin
    numer_next = numer;
    denom_next = denom;
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr && addr_idx == 32'(numer_base(NB)) + i) numer_next[i*8 +: 8] = i_data;
      if (wr && addr_idx == 32'(denom_base(NB)) + i) denom_next[i*8 +: 8] = i_data;
    end
  end

  assign signed_eff = ctrl_wr ? i_data[CTRL_SIGNED] : signed_mode;
  assign ack        = ctrl_wr & i_data[CTRL_ACK];
  assign start      = (ctrl_wr & i_data[CTRL_START]) |
                      (AUTO_START & wr & (addr_idx == 32'(denom_base(NB) + NB - 1)));

  always_ff @(posedge divclk) begin
    if (reset) begin
      numer       <= '0;
      denom       <= '0;
      signed_mode <= 1'b0;
      irq_en      <= 1'b0;
    end else begin
      numer <= numer_next;
      denom <= denom_next;
      if (ctrl_wr) begin
        signed_mode <= i_data[CTRL_SIGNED];
        irq_en      <= i_data[CTRL_IRQ_EN];
      end
    end
  end

  seq_divider_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .divclk      (divclk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .numer       (numer_next),
    .denom       (denom_next),
    .signed_mode (signed_eff),
    .busy        (o_busy),
    .done        (done),
    .div0        (div0),
    .quot        (quot),
    .rem         (rem)
  );

  always_comb begin
    stat              = '0;
    stat[STAT_BUSY]   = o_busy;
    stat[STAT_DONE]   = done;
    stat[STAT_DIV0]   = div0;
    stat[STAT_IRQ_EN] = irq_en;
    stat[STAT_SIGNED] = signed_mode;
  end

  always_comb begin
    o_data = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (addr_idx == 32'(numer_base(NB)) + i) o_data = numer[i*8 +: 8];
      if (addr_idx == 32'(denom_base(NB)) + i) o_data = denom[i*8 +: 8];
      if (addr_idx == 32'(quot_base(NB)) + i)  o_data = quot[i*8 +: 8];
      if (addr_idx == 32'(rem_base(NB)) + i)   o_data = rem[i*8 +: 8];
    end
    if (addr_idx == 32'(ctrl_off(NB))) o_data = stat;
  end

  assign o_irq = done & irq_en;

endmodule

// File: doc/seq_divider_regs.md
Name: seq_divider_regs

Overview:
- Parametrised, memory-mapped integer divider peripheral on the 8-bit 6502-side bus.
- Provides a multi-cycle restoring divide engine, one quotient bit per cycle.
- Supports unsigned and signed modes, busy/done/divide-by-zero status, and an optional interrupt.
- Operand and result widths are a parameter; the CPU accesses them byte-wise.

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of 8, range 8..32.
- AUTO_START, 1, when 1 a write to the most-significant denominator byte also starts an operation.
- NB, WIDTH/8, bytes per operand (derived, not overridable).
- ADDR_W, $clog2(4*NB+1), bus address width (derived).

Ports:
- divclk  in  1  sole clock; all state updates on posedge divclk.
- reset  in  1  synchronous, active-high.
- cs  in  1  chip select, sampled on posedge divclk.
- rwb  in  1  1 = read, 0 = write.
- addr  in  ADDR_W  register byte address.
- i_data  in  8  write data.
- o_data  out  8  read data, combinational from addr.
- o_busy  out  1  operation in progress.
- o_irq  out  1  level interrupt, equals done & irq_en.

Behaviour:
- Clock/reset: reset is synchronous, active-high; clock is divclk.
- Register map (byte offsets, little-endian within each field):
  - 0..NB-1: NUMER, R/W.
  - NB..2NB-1: DENOM, R/W.
  - 2NB..3NB-1: QUOT, read-only.
  - 3NB..4NB-1: REM, read-only.
  - 4NB: CTRL/STAT.
- CTRL write bits:
  - b0 START, self-clearing strobe.
  - b1 SIGNED, sticky.
  - b2 IRQ_EN, sticky.
  - b3 ACK, strobe; clears done and div0.
- STAT read bits: b7 busy, b6 done, b5 div0, b2 irq_en, b1 signed; other bits 0.
- Unmapped addresses, and writes to read-only offsets: reads return 0x00, writes are ignored.
- Reset state:
  - NUMER, DENOM, QUOT, REM = 0.
  - signed, irq_en, done, div0 = 0.
  - State IDLE; o_busy = 0, o_irq = 0.
- Reset mid-operation aborts immediately and returns every register to its reset value.
- Writes occur when cs & ~rwb at the posedge.
- A start is triggered by a START=1 write, or by a write to offset 2NB-1 when AUTO_START=1.
- On start:
  - Operands and the signed mode are latched into internal working registers.
  - NUMER/DENOM stay writable during an operation without affecting it.
  - done and div0 are cleared.
- A start while busy is ignored; the operation in flight continues unaffected.
- A START and ACK in the same write: ACK applies first, then START.
- State machine:
  - IDLE: wait for a start. If the latched denominator is 0, go to FIX with div0 pending; otherwise go to RUN.
  - RUN: iterate WIDTH cycles, shifting the partial remainder (WIDTH+1 bits) and doing a trial subtract; the bit counter counts down from WIDTH-1.
  - FIX: apply signs, write QUOT/REM, set done, go to IDLE.
- Latency:
  - o_busy is high for exactly WIDTH+1 cycles after the start edge, or 1 cycle for divide-by-zero.
  - QUOT/REM and done update on the same edge that busy falls.
- QUOT/REM hold the previous result while busy and are never partially updated.
- Signed mode:
  - Divide the magnitudes; the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend (truncation toward zero).
  - MIN / -1 yields QUOT = MIN, REM = 0, with no error flag.
- Divide by zero: QUOT = all ones, REM = numerator (raw bits, either mode), div0 = 1, done = 1.
- o_irq is a level output: it stays high while done & irq_en and drops on ACK or on a new start.

Decomposition:
- Package seq_divider_pkg holds:
  - State enum (IDLE, RUN, FIX).
  - CTRL/STAT bit-position constants.
  - Offset helper functions of NB (numer_base, denom_base, quot_base, rem_base, ctrl_off).
- One sub-module, seq_divider_core:
  - Contains the WIDTH-parametrised restoring engine, sign handling and FSM.
  - Interface is start/numer/denom/signed in; busy/done/div0/quot/rem out.
- The top level holds the register file, byte-lane decode and read mux.

Test Plan:
- WIDTH=16, unsigned: NUMER=1000, DENOM=7, START -> busy for 17 cycles, then QUOT=0x008E, REM=0x0006, STAT=0x40.
- Signed: NUMER=0xFFF9 (-7), DENOM=0x0002, CTRL=0x03 -> QUOT=0xFFFD, REM=0xFFFF; and 0x8000 / 0xFFFF -> QUOT=0x8000, REM=0x0000, div0=0.
- Divide by zero: NUMER=0x04D2, DENOM=0, START -> busy 1 cycle, QUOT=0xFFFF, REM=0x04D2, STAT=0x60; ACK -> STAT=0x00.
- AUTO_START with IRQ_EN: write offset 3 only -> op runs; o_irq rises with done and falls on the ACK write; a START during busy leaves the result and cycle count unchanged.
- Reset asserted in RUN cycle 5 -> next cycle busy=0, QUOT=0, REM=0, STAT=0x00; reads of offsets 9..15 return 0x00.
- WIDTH=8 and WIDTH=32 builds: 200/3 -> 66 r 2 after 9 cycles; 0xFFFFFFFF/0x10000 -> 0xFFFF r 0xFFFF after 33 cycles.
